// File: rtl/timer_share_scheduler_pkg.sv
// Shared definitions for the interval-timer sharing scheduler.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Holds the timer register map, the control-register bit values and the
// scheduler state encoding.
package timer_share_pkg;

    // Timer slave register addresses
    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;

    // Control register bits
    localparam logic [15:0] CTL_ITO   = 16'h0001;
    localparam logic [15:0] CTL_CONT  = 16'h0002;
    localparam logic [15:0] CTL_START = 16'h0004;
    localparam logic [15:0] CTL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        INIT_STOP,
        INIT_CLR,
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        WAIT,
        STOP,
        CLR,
        DONE
    } state_t;

endpackage

// File: rtl/timer_share_scheduler_rr_arbiter.sv
// Round-robin pick: the first set request at or after ptr, searching modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none. The caller decides when to act on the grant.
// Ports: req (request vector), ptr (search start index), grant (one-hot winner),
//        grant_idx (encoded winner). Both outputs are 0 when req is 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_idx
);

    int   pos;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = 3'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_share_scheduler.sv
// Time-shares one interval timer between NUM_REQ requesters that each ask for a one-shot timeout.
// Latency: accept 1 cycle after IDLE. Each timer write takes at least 2 cycles: an issue cycle, then completion.
// Backpressure: every Avalon write holds address and data stable while avm_waitrequest is high. Requesters wait on req_ready.
// Ports: clk/reset; req_valid/req_ticks/req_ready form the request handshake.
//        cancel aborts the owner's timeout. done/done_cancelled report completion.
//        busy/grant_id show the current owner. avm_* is the write master to the timer s1 port.
//        timer_irq is the timer's level interrupt.
module timer_share_scheduler
    import timer_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TICK_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TICK_W-1:0] req_ticks,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        cancel,
    output logic [NUM_REQ-1:0]        done,
    output logic                      done_cancelled,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [2:0]                avm_address,
    output logic                      avm_write,
    output logic [15:0]               avm_writedata,
    input  logic                      avm_waitrequest,
    input  logic                      timer_irq
);

    state_t               state;
    state_t               wr_next;
    logic [2:0]           ptr;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [TICK_W-1:0]    period;
    logic [TICK_W-1:0]    sel_ticks;
    logic                 cancel_flag;
    logic                 own_cancel;
    logic                 abort;
    logic                 is_wr;
    logic [2:0]           wr_addr;
    logic [15:0]          wr_data;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [2:0]           arb_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        sel_ticks = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) sel_ticks = req_ticks[TICK_W*i +: TICK_W];
        end
    end

    // Only the owner's cancel line matters. cancel_flag remembers a cancel
    // that was seen while a write was still in flight.
    assign own_cancel = |(cancel & grant_oh);
    assign abort      = cancel_flag | own_cancel;

    // Per-state write target and the state that follows a completed write
    always_comb begin
        is_wr   = 1'b1;
        wr_addr = TMR_STATUS;
        wr_data = '0;
        wr_next = IDLE;
        case (state)
            INIT_STOP: begin wr_addr = TMR_CONTROL;  wr_data = CTL_STOP;            wr_next = INIT_CLR; end
            INIT_CLR:  begin                                                        wr_next = IDLE;     end
            WR_PL:     begin wr_addr = TMR_PERIOD_L; wr_data = period[15:0];        wr_next = abort ? STOP : WR_PH;  end
            WR_PH:     begin wr_addr = TMR_PERIOD_H; wr_data = period[31:16];       wr_next = abort ? STOP : WR_CTL; end
            // Period writes stop the timer, so START is always the last write
            WR_CTL:    begin wr_addr = TMR_CONTROL;  wr_data = CTL_ITO | CTL_START; wr_next = abort ? STOP : WAIT;   end
            STOP:      begin wr_addr = TMR_CONTROL;  wr_data = CTL_STOP;            wr_next = CLR;      end
            CLR:       begin                                                        wr_next = DONE;     end
            default:   is_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT_STOP;
            ptr            <= '0;
            grant_oh       <= '0;
            period         <= '0;
            cancel_flag    <= 1'b0;
            req_ready      <= '0;
            done           <= '0;
            done_cancelled <= 1'b0;
            busy           <= 1'b0;
            grant_id       <= '0;
            avm_address    <= '0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            req_ready <= '0;
            done      <= '0;
            if (is_wr) begin
                if (!avm_write) begin
                    avm_write     <= 1'b1;
                    avm_address   <= wr_addr;
                    avm_writedata <= wr_data;
                end else if (!avm_waitrequest) begin
                    avm_write <= 1'b0;
                    state     <= wr_next;
                    if (state == CLR) begin
                        done           <= grant_oh;
                        done_cancelled <= cancel_flag;
                    end
                end
                if ((state == WR_PL || state == WR_PH || state == WR_CTL) && own_cancel)
                    cancel_flag <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (|req_valid) begin
                            req_ready   <= arb_grant;
                            grant_oh    <= arb_grant;
                            grant_id    <= arb_idx;
                            busy        <= 1'b1;
                            ptr         <= (arb_idx == 3'(NUM_REQ-1)) ? 3'd0 : arb_idx + 3'd1;
                            // ticks of 0 behaves like 1: the period register holds ticks-1
                            period      <= (sel_ticks == '0) ? '0 : sel_ticks - TICK_W'(1);
                            cancel_flag <= 1'b0;
                            state       <= WR_PL;
                        end
                    end
                    // When the timeout and a cancel arrive together, the timeout wins
                    WAIT: begin
                        if (timer_irq) begin
                            state <= CLR;
                        end else if (own_cancel) begin
                            cancel_flag <= 1'b1;
                            state       <= STOP;
                        end
                    end
                    DONE: begin
                        busy           <= 1'b0;
                        done_cancelled <= 1'b0;
                        state          <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
